bus_slave_fifo: RTL and testbench

- Responder end of the team's wr/en/rd/data_in bus: accepts master writes and acknowledges each on `rd`.
- Buffers accepted words in a first-word-fall-through FIFO and exposes them to a local consumer through a valid/pop port.
- Sits between a bus master and downstream logic. Write-side backpressure comes from withholding `rd` while the FIFO is full.

---
 rtl/bus_slave_fifo.sv | 86 ++++++++
 tb/tb_bus_slave_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_fifo.sv
// Bus responder that acknowledges master writes on rd and queues them
// in a first-word-fall-through FIFO for a local valid/pop consumer.
module bus_slave_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic             en,
    input  logic [WIDTH-1:0] data_in,
    output logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_q, rd_d;
    logic             ovf_q, ovf_d;
    logic             acc;
    logic             pop_v;

    assign full      = (count_q == CNT_FULL);
    assign out_valid = (count_q != '0);
    assign data_out  = mem_q[rp_q];
    assign count     = count_q;
    assign rd        = rd_q;
    assign overflow  = ovf_q;

    // !rd_q keeps a word still held on the bus from being taken twice
    always_comb begin
        acc     = wr && en && !rd_q && !full;
        pop_v   = pop && out_valid;
        rd_d    = acc;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q || (wr && en && full);
        if (acc) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop_v) begin
            rp_d = rp_q + AW'(1);
        end
        unique case ({acc, pop_v})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            rd_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; out_valid masks stale contents
    always_ff @(posedge clk) begin
        if (acc && !rst) begin
            mem_q[wp_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_bus_slave_fifo.sv
// Directed self-checking bench for bus_slave_fifo (WIDTH=8, DEPTH=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bus_slave_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic       en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd;
    logic [7:0] data_out;
    logic       out_valid;
    logic       pop = 1'b0;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int nvec = 0;
    int nerr = 0;

    bus_slave_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .wr(wr), .en(en), .data_in(data_in),
        .rd(rd), .data_out(data_out), .out_valid(out_valid), .pop(pop),
        .count(count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master side: hold the request until rd is seen, then drop it
    task automatic write_word(input logic [7:0] d);
        bit seen = 0;
        wr = 1'b1; en = 1'b1; data_in = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rd === 1'b1) seen = 1;
        end
        wr = 1'b0; en = 1'b0;
        nvec++;
        if (!seen) begin
            nerr++;
            $display("FAIL write_ack_timeout: data %h got no rd, required rd=1", d);
        end
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b1; en = 1'b1; data_in = 8'h55;
        for (int c = 0; c < 2; c++) begin
            tick();
            nvec++;
            if ({rd, out_valid, full, overflow} !== 4'b0000 || count !== 3'd0) begin
                nerr++;
                $display("FAIL reset_c%0d: rd=%b ov=%b full=%b ovf=%b cnt=%0d, required all 0",
                         c, rd, out_valid, full, overflow, count);
            end
        end
        rst = 1'b0; wr = 1'b0; en = 1'b0;
        tick();
        nvec++;
        if (rd !== 1'b0 || count !== 3'd0) begin
            nerr++;
            $display("FAIL reset_release: rd=%b cnt=%0d, required 0 0", rd, count);
        end
    endtask

    task automatic test_single();
        wr = 1'b1; en = 1'b1; data_in = 8'h2A;
        tick();
        nvec++;
        if (rd !== 1'b1 || out_valid !== 1'b1 || data_out !== 8'h2A || count !== 3'd1) begin
            nerr++;
            $display("FAIL single_accept: rd=%b ov=%b dout=%h cnt=%0d, required 1 1 2a 1",
                     rd, out_valid, data_out, count);
        end
        wr = 1'b0; en = 1'b0;
        tick();
        nvec++;
        if (rd !== 1'b0 || count !== 3'd1) begin
            nerr++;
            $display("FAIL single_rd_pulse: rd=%b cnt=%0d, required 0 1", rd, count);
        end
        do_pop();
        nvec++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL single_pop: cnt=%0d ov=%b, required 0 0", count, out_valid);
        end
    endtask

    task automatic test_fill_stall();
        logic [7:0] exp;
        for (int i = 1; i <= 4; i++) write_word(8'(i));
        nvec++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            nerr++;
            $display("FAIL fill_full: cnt=%0d full=%b ovf=%b, required 4 1 0",
                     count, full, overflow);
        end
        wr = 1'b1; en = 1'b1; data_in = 8'h05;
        for (int c = 0; c < 3; c++) begin
            tick();
            nvec++;
            if (rd !== 1'b0 || count !== 3'd4) begin
                nerr++;
                $display("FAIL stall_c%0d: rd=%b cnt=%0d, required 0 4", c, rd, count);
            end
        end
        nvec++;
        if (overflow !== 1'b1) begin
            nerr++;
            $display("FAIL overflow_set: ovf=%b, required 1", overflow);
        end
        do_pop();
        nvec++;
        if (rd !== 1'b0 || count !== 3'd3 || data_out !== 8'h02) begin
            nerr++;
            $display("FAIL pop_while_full: rd=%b cnt=%0d dout=%h, required 0 3 02",
                     rd, count, data_out);
        end
        tick();
        nvec++;
        if (rd !== 1'b1 || count !== 3'd4) begin
            nerr++;
            $display("FAIL late_accept: rd=%b cnt=%0d, required 1 4", rd, count);
        end
        wr = 1'b0; en = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            exp = 8'(i);
            nvec++;
            if (out_valid !== 1'b1 || data_out !== exp) begin
                nerr++;
                $display("FAIL drain_%0d: ov=%b dout=%h, required 1 %h",
                         i, out_valid, data_out, exp);
            end
            do_pop();
        end
        nvec++;
        if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            nerr++;
            $display("FAIL drain_end: cnt=%0d ov=%b ovf=%b, required 0 0 1",
                     count, out_valid, overflow);
        end
    endtask

    task automatic test_simultaneous();
        write_word(8'h30);
        write_word(8'h31);
        tick();
        wr = 1'b1; en = 1'b1; data_in = 8'h77; pop = 1'b1;
        tick();
        pop = 1'b0; wr = 1'b0; en = 1'b0;
        nvec++;
        if (rd !== 1'b1 || count !== 3'd2 || data_out !== 8'h31) begin
            nerr++;
            $display("FAIL simul_both: rd=%b cnt=%0d dout=%h, required 1 2 31",
                     rd, count, data_out);
        end
        do_pop();
        nvec++;
        if (data_out !== 8'h77 || count !== 3'd1) begin
            nerr++;
            $display("FAIL simul_last: dout=%h cnt=%0d, required 77 1", data_out, count);
        end
        do_pop();
        nvec++;
        if (count !== 3'd0) begin
            nerr++;
            $display("FAIL simul_empty: cnt=%0d, required 0", count);
        end
    endtask

    task automatic test_wrap_empty_pop();
        logic [7:0] exp;
        for (int i = 0; i < 10; i++) begin
            exp = 8'h10 + 8'(i);
            write_word(exp);
            nvec++;
            if (out_valid !== 1'b1 || data_out !== exp) begin
                nerr++;
                $display("FAIL wrap_%0d: ov=%b dout=%h, required 1 %h",
                         i, out_valid, data_out, exp);
            end
            do_pop();
        end
        do_pop();
        nvec++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL empty_pop: cnt=%0d ov=%b, required 0 0", count, out_valid);
        end
        write_word(8'h5A);
        nvec++;
        if (count !== 3'd1 || data_out !== 8'h5A) begin
            nerr++;
            $display("FAIL after_empty_pop: cnt=%0d dout=%h, required 1 5a", count, data_out);
        end
        do_pop();
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        write_word(8'hA1);
        write_word(8'hA2);
        wr = 1'b1; en = 1'b1; data_in = 8'hA3;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rd === 1'b1) seen = 1;
        end
        nvec++;
        if (!seen || count !== 3'd3 || overflow !== 1'b1) begin
            nerr++;
            $display("FAIL midrst_setup: rd_seen=%b cnt=%0d ovf=%b, required 1 3 1",
                     seen, count, overflow);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvec++;
        if ({rd, out_valid, overflow} !== 3'b000 || count !== 3'd0) begin
            nerr++;
            $display("FAIL midrst_clear: rd=%b ov=%b ovf=%b cnt=%0d, required 0 0 0 0",
                     rd, out_valid, overflow, count);
        end
        tick();
        wr = 1'b0; en = 1'b0;
        nvec++;
        if (rd !== 1'b1 || count !== 3'd1 || data_out !== 8'hA3) begin
            nerr++;
            $display("FAIL midrst_reaccept: rd=%b cnt=%0d dout=%h, required 1 1 a3",
                     rd, count, data_out);
        end
        do_pop();
        nvec++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            nerr++;
            $display("FAIL midrst_drain: cnt=%0d ov=%b, required 0 0", count, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_stall();
        test_simultaneous();
        test_wrap_empty_pop();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
